// File: rtl/shot_pkg.sv
// Shared types and constants for the multi-shot bullet pool.
package shot_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StErase,
        StMove,
        StDraw
    } shot_state_e;

    localparam logic [2:0] COLOUR_ERASE = 3'b000;
    localparam logic [2:0] COLOUR_DRAW  = 3'b111;

    localparam int unsigned DEFAULT_START_Y = 105;
    localparam int unsigned DEFAULT_STEP    = 5;

    // Index width for n slots, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shot_pool_if.sv
// Pixel request channel from the shot pool to the VGA plotter (valid/ready).
interface shot_pool_if #(
    parameter int unsigned X_W   = 8,
    parameter int unsigned Y_W   = 7,
    parameter int unsigned IDX_W = 2
);
    logic             draw_valid;
    logic             draw_ready;
    logic [X_W-1:0]   draw_x;
    logic [Y_W-1:0]   draw_y;
    logic [2:0]       draw_colour;
    logic [IDX_W-1:0] draw_idx;

    modport master (
        output draw_valid, draw_x, draw_y, draw_colour, draw_idx,
        input  draw_ready
    );

    modport slave (
        input  draw_valid, draw_x, draw_y, draw_colour, draw_idx,
        output draw_ready
    );
endinterface

// File: rtl/shot_slot_alloc.sv
// Lowest-index free slot finder for fire allocation.
module shot_slot_alloc #(
    parameter int unsigned NUM_SHOTS = 4,
    parameter int unsigned IDX_W     = 2
) (
    input  logic [NUM_SHOTS-1:0] free_mask,
    output logic [IDX_W-1:0]     free_idx,
    output logic                 found
);
    // Scan downwards so the lowest free index is the last one written.
    always_comb begin
        free_idx = '0;
        found    = 1'b0;
        for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                free_idx = IDX_W'(i);
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/shot_pool.sv
// Multi-shot bullet pool: fire allocation, per-frame motion, retirement and hit kills.
// Optional fire cooldown is enabled by defining SHOT_POOL_COOLDOWN_EN.
module shot_pool
    import shot_pkg::*;
#(
    parameter int unsigned NUM_SHOTS = 4,
    parameter int unsigned X_W       = 8,
    parameter int unsigned Y_W       = 7,
    parameter int unsigned START_Y   = DEFAULT_START_Y,
    parameter int unsigned STEP      = DEFAULT_STEP,
    parameter int unsigned COOLDOWN  = 3,
    localparam int unsigned IDX_W    = idx_width(NUM_SHOTS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_tick,
    input  logic                     fire,
    input  logic [X_W-1:0]           xin,
    input  logic                     hit_valid,
    input  logic [IDX_W-1:0]         hit_idx,
    shot_pool_if.master              draw,
    output logic [NUM_SHOTS-1:0]     active_mask,
    output logic [NUM_SHOTS*X_W-1:0] shot_x_flat,
    output logic [NUM_SHOTS*Y_W-1:0] shot_y_flat,
    output logic                     fire_ack,
    output logic                     top_pulse,
    output logic                     busy,
    output logic                     overrun
);
    localparam logic [Y_W-1:0]   START_YV = Y_W'(START_Y);
    localparam logic [Y_W-1:0]   STEP_V   = Y_W'(STEP);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SHOTS - 1);

    shot_state_e          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [X_W-1:0]       x_q [NUM_SHOTS];
    logic [X_W-1:0]       x_d [NUM_SHOTS];
    logic [Y_W-1:0]       y_q [NUM_SHOTS];
    logic [Y_W-1:0]       y_d [NUM_SHOTS];
    logic [NUM_SHOTS-1:0] live_q, live_d, dying_q, dying_d;
    logic                 pending_q, pending_d, overrun_q, overrun_d;
    logic                 fire_ack_q, fire_ack_d, top_pulse_q, top_pulse_d;
    logic                 advance, cd_ok, found;
    logic [IDX_W-1:0]     free_idx;

    shot_slot_alloc #(.NUM_SHOTS(NUM_SHOTS), .IDX_W(IDX_W)) u_alloc (
        .free_mask (~(live_q | dying_q)),
        .free_idx  (free_idx),
        .found     (found)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x_d         = x_q;
        y_d         = y_q;
        live_d      = live_q;
        dying_d     = dying_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q | (frame_tick && state_q != StIdle);
        fire_ack_d  = 1'b0;
        top_pulse_d = 1'b0;
        advance     = 1'b0;

        if (hit_valid && 32'(hit_idx) < NUM_SHOTS && live_q[hit_idx]) begin
            live_d[hit_idx]  = 1'b0;
            dying_d[hit_idx] = 1'b1;
        end

        // A fire coinciding with frame_tick waits so the new slot is not drawn this sweep.
        if (state_q == StIdle && !frame_tick) begin
            pending_d = 1'b0;
            if ((fire || pending_q) && cd_ok && found) begin
                x_d[free_idx]    = xin;
                y_d[free_idx]    = START_YV;
                live_d[free_idx] = 1'b1;
                fire_ack_d       = 1'b1;
            end
        end else if (fire && cd_ok) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (frame_tick) begin
                    idx_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (live_q[idx_q] || dying_q[idx_q]) state_d = StErase;
                else                                 advance = 1'b1;
            end
            StErase: begin
                if (draw.draw_ready) begin
                    if (dying_q[idx_q]) begin
                        dying_d[idx_q] = 1'b0;
                        advance        = 1'b1;
                    end else begin
                        state_d = StMove;
                    end
                end
            end
            StMove: begin
                if (y_q[idx_q] < STEP_V) begin
                    y_d[idx_q]     = START_YV;
                    live_d[idx_q]  = 1'b0;
                    dying_d[idx_q] = 1'b0;
                    top_pulse_d    = 1'b1;
                    advance        = 1'b1;
                end else begin
                    y_d[idx_q] = y_q[idx_q] - STEP_V;
                    state_d    = StDraw;
                end
            end
            StDraw: begin
                if (draw.draw_ready) advance = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (advance) begin
            if (idx_q == LAST_IDX) begin
                state_d = StIdle;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = StScan;
            end
        end
    end

`ifdef SHOT_POOL_COOLDOWN_EN
    localparam int unsigned CD_W = idx_width(COOLDOWN + 1);
    logic [CD_W-1:0] cd_q, cd_d;

    assign cd_ok = (cd_q == '0);

    always_comb begin
        cd_d = cd_q;
        if (fire_ack_d)                   cd_d = CD_W'(COOLDOWN);
        else if (frame_tick && !cd_ok)    cd_d = cd_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cd_q <= '0;
        else        cd_q <= cd_d;
    end
`else
    logic unused_cooldown;
    assign unused_cooldown = ^COOLDOWN;
    assign cd_ok           = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            live_q      <= '0;
            dying_q     <= '0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            fire_ack_q  <= 1'b0;
            top_pulse_q <= 1'b0;
            for (int i = 0; i < NUM_SHOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= START_YV;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            live_q      <= live_d;
            dying_q     <= dying_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            fire_ack_q  <= fire_ack_d;
            top_pulse_q <= top_pulse_d;
            x_q         <= x_d;
            y_q         <= y_d;
        end
    end

    assign draw.draw_valid  = (state_q == StErase) || (state_q == StDraw);
    assign draw.draw_x      = draw.draw_valid ? x_q[idx_q] : '0;
    assign draw.draw_y      = draw.draw_valid ? y_q[idx_q] : '0;
    assign draw.draw_colour = (state_q == StDraw) ? COLOUR_DRAW : COLOUR_ERASE;
    assign draw.draw_idx    = idx_q;

    for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_flat
        assign shot_x_flat[g*X_W +: X_W] = x_q[g];
        assign shot_y_flat[g*Y_W +: Y_W] = y_q[g];
    end

    assign active_mask = live_q;
    assign fire_ack    = fire_ack_q;
    assign top_pulse   = top_pulse_q;
    assign busy        = (state_q != StIdle);
    assign overrun     = overrun_q;
endmodule

// File: tb/tb_shot_pool.sv
// Self-checking bench for shot_pool: vector table plus scoreboarded draw requests.
module tb_shot_pool;
    localparam int unsigned N  = 4;
    localparam int unsigned XW = 8;
    localparam int unsigned YW = 7;
    localparam int unsigned IW = 2;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [2:0]    c;
        logic [IW-1:0] i;
    } req_t;

    typedef struct {
        logic          f;
        logic [XW-1:0] x;
        logic          h;
        logic [IW-1:0] hi;
        logic          ack;
        logic [N-1:0]  mask;
    } vec_t;

    logic clk = 1'b0, reset = 1'b0, frame_tick = 1'b0, fire = 1'b0, hit_valid = 1'b0;
    logic [XW-1:0]   xin = '0;
    logic [IW-1:0]   hit_idx = '0;
    logic [N-1:0]    active_mask;
    logic [N*XW-1:0] shot_x_flat;
    logic [N*YW-1:0] shot_y_flat;
    logic            fire_ack, top_pulse, busy, overrun;

    shot_pool_if #(.X_W(XW), .Y_W(YW), .IDX_W(IW)) dif ();

    shot_pool #(.NUM_SHOTS(N), .X_W(XW), .Y_W(YW)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .fire        (fire),
        .xin         (xin),
        .hit_valid   (hit_valid),
        .hit_idx     (hit_idx),
        .draw        (dif),
        .active_mask (active_mask),
        .shot_x_flat (shot_x_flat),
        .shot_y_flat (shot_y_flat),
        .fire_ack    (fire_ack),
        .top_pulse   (top_pulse),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int   total = 0, bad = 0, top_seen = 0, ack_seen = 0, mtop = 0;
    req_t exp_q[$];
    req_t mon_got, mon_exp;

    logic [XW-1:0] mx [N];
    logic [YW-1:0] my [N];
    logic [N-1:0]  mlive, mdying;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (reset && top_pulse) top_seen++;
        if (reset && fire_ack) ack_seen++;
        if (reset && dif.draw_valid && dif.draw_ready) begin
            mon_got = '{x: dif.draw_x, y: dif.draw_y, c: dif.draw_colour, i: dif.draw_idx};
            if (exp_q.size() == 0) begin
                chk("draw_unexpected", 64'(mon_got), 64'hffff_ffff);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("draw_req", 64'(mon_got), 64'(mon_exp));
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = '0;
            my[i] = 7'd105;
        end
        mlive  = '0;
        mdying = '0;
    endtask

    task automatic model_fire(input logic [XW-1:0] x);
        for (int i = 0; i < N; i++) begin
            if (!mlive[i] && !mdying[i]) begin
                mx[i]    = x;
                my[i]    = 7'd105;
                mlive[i] = 1'b1;
                return;
            end
        end
    endtask

    task automatic model_hit(input int i);
        if (mlive[i]) begin
            mlive[i]  = 1'b0;
            mdying[i] = 1'b1;
        end
    endtask

    task automatic model_sweep();
        req_t r;
        for (int i = 0; i < N; i++) begin
            if (mlive[i] || mdying[i]) begin
                r = '{x: mx[i], y: my[i], c: 3'b000, i: IW'(i)};
                exp_q.push_back(r);
                if (mdying[i]) begin
                    mdying[i] = 1'b0;
                end else if (my[i] < 7'd5) begin
                    my[i]    = 7'd105;
                    mlive[i] = 1'b0;
                    mtop++;
                end else begin
                    my[i] = my[i] - 7'd5;
                    r = '{x: mx[i], y: my[i], c: 3'b111, i: IW'(i)};
                    exp_q.push_back(r);
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            cyc();
            n++;
        end
        chk(name, 64'(busy), 64'd0);
    endtask

    task automatic wait_colour(input string name, input logic [2:0] col);
        int n = 0;
        while (!(dif.draw_valid && dif.draw_colour == col) && n < 50) begin
            cyc();
            n++;
        end
        chk(name, 64'(dif.draw_valid), 64'd1);
    endtask

    task automatic do_fire(input logic [XW-1:0] x);
        xin  = x;
        fire = 1'b1;
        cyc();
        fire = 1'b0;
    endtask

    task automatic sweep();
        model_sweep();
        pulse_tick();
        wait_idle("sweep_idle");
        cyc();
    endtask

    vec_t tbl[8];
    int   n, a0;

    initial begin
        tbl[0] = '{1'b1, 8'd10, 1'b0, 2'd0, 1'b1, 4'b0011};
        tbl[1] = '{1'b1, 8'd20, 1'b0, 2'd0, 1'b1, 4'b0111};
        tbl[2] = '{1'b1, 8'd30, 1'b0, 2'd0, 1'b1, 4'b1111};
        tbl[3] = '{1'b1, 8'd50, 1'b0, 2'd0, 1'b0, 4'b1111};
        tbl[4] = '{1'b0, 8'd0,  1'b0, 2'd0, 1'b0, 4'b1111};
        tbl[5] = '{1'b0, 8'd0,  1'b1, 2'd2, 1'b0, 4'b1011};
        tbl[6] = '{1'b1, 8'd60, 1'b1, 2'd1, 1'b0, 4'b1001};
        tbl[7] = '{1'b0, 8'd0,  1'b1, 2'd2, 1'b0, 4'b1001};

        dif.draw_ready = 1'b1;
        model_reset();
        #12;
        chk("reset_mask", 64'(active_mask), 64'd0);
        chk("reset_valid", 64'(dif.draw_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_overrun", 64'(overrun), 64'd0);
        chk("reset_ack", 64'(fire_ack), 64'd0);
        chk("reset_y0", 64'(shot_y_flat[YW-1:0]), 64'd105);
        @(posedge clk);
        #1;
        reset = 1'b1;

        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        n = 1;
        while (busy && n < 50) begin
            cyc();
            n++;
        end
        chk("idle_latency", 64'(n), 64'(N + 1));

        do_fire(8'd40);
        chk("fire1_ack", 64'(fire_ack), 64'd1);
        chk("fire1_x", 64'(shot_x_flat[XW-1:0]), 64'd40);
        chk("fire1_y", 64'(shot_y_flat[YW-1:0]), 64'd105);
        model_fire(8'd40);
        sweep();
        chk("sweep1_drained", 64'(exp_q.size()), 64'd0);

`ifdef SHOT_POOL_COOLDOWN_EN
        do_fire(8'd41);
        chk("cd_block_ack", 64'(fire_ack), 64'd0);
        sweep();
        sweep();
        do_fire(8'd42);
        chk("cd_release_ack", 64'(fire_ack), 64'd1);
        chk("cd_mask", 64'(active_mask), 64'b0011);
        chk("cd_drained", 64'(exp_q.size()), 64'd0);
`else
        for (int k = 0; k < 8; k++) begin
            fire      = tbl[k].f;
            xin       = tbl[k].x;
            hit_valid = tbl[k].h;
            hit_idx   = tbl[k].hi;
            if (tbl[k].h) model_hit(int'(tbl[k].hi));
            if (tbl[k].f) model_fire(tbl[k].x);
            cyc();
            fire      = 1'b0;
            hit_valid = 1'b0;
            chk($sformatf("vec%0d_ack", k), 64'(fire_ack), 64'(tbl[k].ack));
            chk($sformatf("vec%0d_mask", k), 64'(active_mask), 64'(tbl[k].mask));
        end

        sweep();
        chk("hit_sweep_drained", 64'(exp_q.size()), 64'd0);
        do_fire(8'd70);
        chk("reuse1_ack", 64'(fire_ack), 64'd1);
        model_fire(8'd70);
        do_fire(8'd80);
        chk("reuse2_ack", 64'(fire_ack), 64'd1);
        model_fire(8'd80);
        chk("reuse_slot2_x", 64'(shot_x_flat[2*XW +: XW]), 64'd80);
        chk("reuse_mask", 64'(active_mask), 64'b1111);

        for (int k = 0; k < 23; k++) sweep();
        chk("top_drained", 64'(exp_q.size()), 64'd0);
        chk("top_pulses", 64'(top_seen), 64'(mtop));
        chk("top_mask", 64'(active_mask), 64'd0);
        chk("top_y0", 64'(shot_y_flat[YW-1:0]), 64'd105);

        do_fire(8'd90);
        chk("stall_fire_ack", 64'(fire_ack), 64'd1);
        model_fire(8'd90);
        dif.draw_ready = 1'b0;
        model_sweep();
        pulse_tick();
        wait_colour("stall_erase_seen", 3'b000);
        a0 = ack_seen;
        for (int j = 0; j < 10; j++) begin
            chk("stall_x", 64'(dif.draw_x), 64'd90);
            chk("stall_y", 64'(dif.draw_y), 64'd105);
            chk("stall_colour", 64'(dif.draw_colour), 64'd0);
            if (j == 3) frame_tick = 1'b1;
            if (j == 5) begin
                fire = 1'b1;
                xin  = 8'd11;
            end
            cyc();
            frame_tick = 1'b0;
            fire       = 1'b0;
        end
        chk("stall_overrun", 64'(overrun), 64'd1);
        chk("stall_busy", 64'(busy), 64'd1);
        dif.draw_ready = 1'b1;
        wait_idle("stall_idle");
        cyc();
        cyc();
        model_fire(8'd11);
        chk("pending_ack", 64'(ack_seen - a0), 64'd1);
        chk("pending_mask", 64'(active_mask), 64'b0011);
        chk("pending_x", 64'(shot_x_flat[XW +: XW]), 64'd11);
        chk("stall_drained", 64'(exp_q.size()), 64'd0);

        dif.draw_ready = 1'b0;
        model_sweep();
        pulse_tick();
        wait_colour("rst_erase_seen", 3'b000);
        dif.draw_ready = 1'b1;
        cyc();
        dif.draw_ready = 1'b0;
        wait_colour("rst_draw_seen", 3'b111);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 64'(dif.draw_valid), 64'd0);
        chk("async_rst_mask", 64'(active_mask), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        model_reset();
        dif.draw_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        do_fire(8'd5);
        chk("post_rst_ack", 64'(fire_ack), 64'd1);
        chk("post_rst_x0", 64'(shot_x_flat[XW-1:0]), 64'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
